// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The queue side takes the slave modport; the fetch/decode environment drives the master.
interface fetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic [31:0]   in_pc;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc;
   logic [CW-1:0] count;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, count
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Circular {pc, instr} buffer between fetch and decode, cleared in one cycle by a redirect flush.
// Entries leave in push order; a pushed entry is visible on out_* one cycle later.
module fetch_queue #(
   parameter int          DEPTH = 4,
   parameter logic [31:0] NOP   = 32'h00000013
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.slave fq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [63:0]   head;

   // Valid/ready: a transfer happens on an edge only when valid and ready are both high
   // in that cycle; valid may be held while ready is low and nothing moves.
   assign fq.in_ready  = (count_q != CW'(DEPTH));
   assign fq.out_valid = (count_q != '0);
   assign push         = fq.in_valid & fq.in_ready;
   assign pop          = fq.out_valid & fq.out_ready;

   assign head         = mem_q[rd_ptr_q];
   assign fq.out_instr = fq.out_valid ? head[31:0]  : NOP;
   assign fq.out_pc    = fq.out_valid ? head[63:32] : 32'h0;
   assign fq.count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (fq.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; a push coinciding with flush or reset is dropped.
   always_ff @(posedge clk) begin
      if (push && !fq.flush && !reset)
         mem_q[wr_ptr_q] <= {fq.in_pc, fq.in_instr};
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, drain, streaming with wrap, flush, full+pop.
module tb_fetch_queue;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   logic [31:0] exp_q[$];

   fetch_queue_if #(.DEPTH(4)) fq_if ();

   fetch_queue #(.DEPTH(4), .NOP(32'h00000013)) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq_if)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one edge; outputs are then read 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
      fq_if.in_valid  = v;
      fq_if.in_pc     = pc;
      fq_if.in_instr  = 32'hA000_0000 | pc;
      fq_if.out_ready = rdy;
      fq_if.flush     = fl;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);

      // 1. reset
      step();
      step();
      reset = 1'b0;
      check("rst_count", 64'(fq_if.count), 64'd0);
      check("rst_out_valid", 64'(fq_if.out_valid), 64'd0);
      check("rst_out_instr", 64'(fq_if.out_instr), 64'h13);
      check("rst_out_pc", 64'(fq_if.out_pc), 64'h0);
      check("rst_in_ready", 64'(fq_if.in_ready), 64'd1);

      // 2. fill with decode stalled
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
         step();
         check("fill_count", 64'(fq_if.count), 64'(i + 1));
      end
      check("fill_in_ready", 64'(fq_if.in_ready), 64'd0);
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      step();
      check("fill_5th_count", 64'(fq_if.count), 64'd4);
      check("fill_head_pc", 64'(fq_if.out_pc), 64'h0);
      check("fill_head_instr", 64'(fq_if.out_instr), 64'hA000_0000);

      // 3. drain
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", 64'(fq_if.out_valid), 64'd1);
         check("drain_pc", 64'(fq_if.out_pc), 64'(i * 4));
         step();
      end
      check("drain_out_valid", 64'(fq_if.out_valid), 64'd0);
      check("drain_count", 64'(fq_if.count), 64'd0);
      check("drain_out_instr", 64'(fq_if.out_instr), 64'h13);

      // 4. streaming, 10 cycles, pointers wrap
      for (int k = 0; k < 10; k++) begin
         if (k > 0) check("stream_pc", 64'(fq_if.out_pc), 64'(exp_q.pop_front()));
         drive(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0);
         exp_q.push_back(32'h100 + 32'(4 * k));
         step();
         check("stream_count", 64'(fq_if.count), 64'd1);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("stream_last_pc", 64'(fq_if.out_pc), 64'(exp_q.pop_front()));
      check("stream_last_instr", 64'(fq_if.out_instr), 64'hA000_0124);
      step();
      check("stream_end_count", 64'(fq_if.count), 64'd0);

      // 5. flush with a same-cycle push
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
         step();
      end
      check("pre_flush_count", 64'(fq_if.count), 64'd3);
      drive(1'b1, 32'h200, 1'b0, 1'b1);
      step();
      check("flush_count", 64'(fq_if.count), 64'd0);
      check("flush_out_valid", 64'(fq_if.out_valid), 64'd0);
      check("flush_out_pc", 64'(fq_if.out_pc), 64'h0);
      drive(1'b1, 32'h400, 1'b0, 1'b0);
      step();
      check("post_flush_pc", 64'(fq_if.out_pc), 64'h400);
      check("post_flush_count", 64'(fq_if.count), 64'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      check("post_flush_drain", 64'(fq_if.count), 64'd0);

      // 6. full + single pop
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
         step();
      end
      check("full_count", 64'(fq_if.count), 64'd4);
      check("full_in_ready", 64'(fq_if.in_ready), 64'd0);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("fullpop_count", 64'(fq_if.count), 64'd3);
      check("fullpop_in_ready", 64'(fq_if.in_ready), 64'd1);
      check("fullpop_head", 64'(fq_if.out_pc), 64'h504);

      // reset mid-operation clears like flush
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_count", 64'(fq_if.count), 64'd0);
      check("midrst_out_valid", 64'(fq_if.out_valid), 64'd0);
      check("midrst_in_ready", 64'(fq_if.in_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
